// File: rtl/ctrl_pkg.sv
// Shared types for the multicycle control unit: FSM states, opcode classes,
// opcode constants, alu_op codes and the Moore output decode.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_NONE  = 4'd0,
        CLS_R     = 4'd1,
        CLS_I     = 4'd2,
        CLS_LW    = 4'd3,
        CLS_SW    = 4'd4,
        CLS_BEQ   = 4'd5,
        CLS_JAL   = 4'd6,
        CLS_JALR  = 4'd7,
        CLS_LUI   = 4'd8,
        CLS_AUIPC = 4'd9
    } opc_class_e;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_BEQ   = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_IMM    = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       trap;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        reg_write:  1'b0,
        alu_src:    1'b0,
        mem_to_reg: 1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        branch:     1'b0,
        trap:       1'b0,
        alu_op:     2'b00
    };

    function automatic logic is_jump_class(input opc_class_e cls);
        return (cls == CLS_JAL) || (cls == CLS_JALR);
    endfunction

    // Moore control word for a given state and latched instruction class.
    function automatic ctrl_t ctrl_decode(input state_e st, input opc_class_e cls);
        ctrl_t c;
        c = CTRL_IDLE;
        case (st)
            ST_FETCH: c.mem_read = 1'b1;
            ST_DECODE: c = CTRL_IDLE;
            ST_EXEC: begin
                case (cls)
                    CLS_R: c.alu_op = ALU_RTYPE;
                    CLS_I: begin
                        c.alu_op  = ALU_IMM;
                        c.alu_src = 1'b1;
                    end
                    CLS_LW, CLS_SW, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC: begin
                        c.alu_op  = ALU_ADD;
                        c.alu_src = 1'b1;
                    end
                    CLS_BEQ: begin
                        c.alu_op = ALU_BRANCH;
                        c.branch = 1'b1;
                    end
                    default: c = CTRL_IDLE;
                endcase
            end
            ST_MEM: begin
                case (cls)
                    CLS_LW:  c.mem_read  = 1'b1;
                    CLS_SW:  c.mem_write = 1'b1;
                    default: c = CTRL_IDLE;
                endcase
            end
            ST_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = (cls == CLS_LW);
            end
            ST_TRAP: c.trap = 1'b1;
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode -> instruction class / legality lookup.
// RV_CTRL_JUMP_EN makes JAL, JALR, LUI and AUIPC legal.
module opcode_classifier
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [3:0] o_class,
    output logic       o_legal
);

    // Map opcode to class; anything unrecognised is illegal.
    always_comb begin
        o_class = CLS_NONE;
        o_legal = 1'b1;
        case (i_opcode)
            OPC_R:     o_class = CLS_R;
            OPC_I:     o_class = CLS_I;
            OPC_LW:    o_class = CLS_LW;
            OPC_SW:    o_class = CLS_SW;
            OPC_BEQ:   o_class = CLS_BEQ;
`ifdef RV_CTRL_JUMP_EN
            OPC_JAL:   o_class = CLS_JAL;
            OPC_JALR:  o_class = CLS_JALR;
            OPC_LUI:   o_class = CLS_LUI;
            OPC_AUIPC: o_class = CLS_AUIPC;
`endif
            default: begin
                o_class = CLS_NONE;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control FSM with memory-wait timeout trap.
// Optional macro RV_CTRL_JUMP_EN enables JAL/JALR/LUI/AUIPC and the jump output.
module multicycle_control_unit
    import ctrl_pkg::*;
#(
    parameter int ALUOP_W      = 2,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic               mem_read,
    output logic               mem_write,
    output logic               branch,
    output logic               jump,
    output logic               trap,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         state
);

    localparam int             CNT_W     = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    state_e           r_state;
    state_e           w_next_state;
    opc_class_e       r_class;
    opc_class_e       w_next_class;
    logic [3:0]       w_dec_class;
    logic             w_dec_legal;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_next_wait;
    ctrl_t            r_ctrl;
    logic             w_fetch_done;

    opcode_classifier u_classifier (
        .i_opcode (opcode),
        .o_class  (w_dec_class),
        .o_legal  (w_dec_legal)
    );

    // Next state, next latched class and wait counter; counter resets on any state change.
    always_comb begin
        w_next_state = r_state;
        w_next_class = r_class;
        w_next_wait  = {CNT_W{1'b0}};
        case (r_state)
            ST_FETCH: begin
                if (mem_ready) begin
                    w_next_state = ST_DECODE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_next_state = ST_TRAP;
                end else begin
                    w_next_wait = r_wait_cnt + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                if (w_dec_legal) begin
                    w_next_state = ST_EXEC;
                    w_next_class = opc_class_e'(w_dec_class);
                end else begin
                    w_next_state = ST_TRAP;
                    w_next_class = CLS_NONE;
                end
            end
            ST_EXEC: begin
                case (r_class)
                    CLS_R, CLS_I, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC: w_next_state = ST_WB;
                    CLS_LW, CLS_SW: w_next_state = ST_MEM;
                    CLS_BEQ:        w_next_state = ST_FETCH;
                    default:        w_next_state = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    case (r_class)
                        CLS_LW:  w_next_state = ST_WB;
                        CLS_SW:  w_next_state = ST_FETCH;
                        default: w_next_state = ST_TRAP;
                    endcase
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_next_state = ST_TRAP;
                end else begin
                    w_next_wait = r_wait_cnt + CNT_W'(1);
                end
            end
            ST_WB:   w_next_state = ST_FETCH;
            ST_TRAP: w_next_state = ST_TRAP;
            default: w_next_state = ST_TRAP;
        endcase
    end

`ifdef RV_CTRL_JUMP_EN
    logic r_jump;
`endif

    // State register plus registered Moore outputs decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH;
            r_class    <= CLS_NONE;
            r_wait_cnt <= {CNT_W{1'b0}};
            r_ctrl     <= ctrl_decode(ST_FETCH, CLS_NONE);
`ifdef RV_CTRL_JUMP_EN
            r_jump     <= 1'b0;
`endif
        end else begin
            r_state    <= w_next_state;
            r_class    <= w_next_class;
            r_wait_cnt <= w_next_wait;
            r_ctrl     <= ctrl_decode(w_next_state, w_next_class);
`ifdef RV_CTRL_JUMP_EN
            r_jump     <= (w_next_state == ST_EXEC) && is_jump_class(w_next_class);
`endif
        end
    end

    // Reset masks every control output, including the FETCH mem_read held in r_ctrl.
    assign w_fetch_done = (r_state == ST_FETCH) & mem_ready & rst_n;
    assign pc_write     = w_fetch_done;
    assign ir_write     = w_fetch_done;
    assign reg_write    = r_ctrl.reg_write  & rst_n;
    assign alu_src      = r_ctrl.alu_src    & rst_n;
    assign mem_to_reg   = r_ctrl.mem_to_reg & rst_n;
    assign mem_read     = r_ctrl.mem_read   & rst_n;
    assign mem_write    = r_ctrl.mem_write  & rst_n;
    assign branch       = r_ctrl.branch     & rst_n;
    assign trap         = r_ctrl.trap       & rst_n;
    assign alu_op       = ALUOP_W'(r_ctrl.alu_op & {2{rst_n}});
    assign state        = r_state;
`ifdef RV_CTRL_JUMP_EN
    assign jump         = r_jump & rst_n;
`else
    assign jump         = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised self-checking bench: an instruction-level plan model builds the
// expected per-cycle output trace, which is compared against the DUT each cycle.
module tb_multicycle_control_unit;

    localparam int ALUOP_W = 3;
    localparam int MAXW    = 15;
`ifdef RV_CTRL_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_ILL = 9;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [6:0]         opcode;
    logic               mem_ready;
    logic               pc_write, ir_write, reg_write, alu_src, mem_to_reg;
    logic               mem_read, mem_write, branch, jump, trap;
    logic [ALUOP_W-1:0] alu_op;
    logic [2:0]         state;

    typedef struct packed {
        logic [2:0] st;
        logic pcw, irw, rw, asrc, m2r, mrd, mwr, br, jmp, trp;
        logic [2:0] aop;
    } obs_t;

    obs_t       exp_q[$];
    bit         mr_q[$];
    logic [6:0] op_q[$];
    int         total = 0;
    int         bad   = 0;

    multicycle_control_unit #(.ALUOP_W(ALUOP_W), .MEM_WAIT_MAX(MAXW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .jump(jump), .trap(trap),
        .alu_op(alu_op), .state(state)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.st = state;      o.pcw = pc_write;   o.irw = ir_write;
        o.rw = reg_write;  o.asrc = alu_src;   o.m2r = mem_to_reg;
        o.mrd = mem_read;  o.mwr = mem_write;  o.br = branch;
        o.jmp = jump;      o.trp = trap;       o.aop = alu_op;
        return o;
    endfunction

    function automatic obs_t idle(input logic [2:0] st);
        obs_t e;
        e = '0;
        e.st = st;
        return e;
    endfunction

    function automatic int kind_of(input logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b1100011: return K_BEQ;
            7'b1101111: return JUMP_EN ? K_JAL   : K_ILL;
            7'b1100111: return JUMP_EN ? K_JALR  : K_ILL;
            7'b0110111: return JUMP_EN ? K_LUI   : K_ILL;
            7'b0010111: return JUMP_EN ? K_AUIPC : K_ILL;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    task automatic clear_plan();
        exp_q.delete();
        mr_q.delete();
        op_q.delete();
    endtask

    task automatic push(input obs_t e, input bit mr, input logic [6:0] op);
        exp_q.push_back(e);
        mr_q.push_back(mr);
        op_q.push_back(op);
    endtask

    task automatic plan_trap(input int n);
        obs_t e;
        for (int i = 0; i < n; i++) begin
            e = idle(3'd5);
            e.trp = 1'b1;
            push(e, rbit(), rop());
        end
    endtask

    // Memory wait phase: MAXW consecutive not-ready cycles end in a trap.
    task automatic plan_wait(input logic [2:0] st, input bit rd, input bit wr,
                             input int waits, output bit trapped);
        obs_t e;
        int   n;
        n = (waits < MAXW) ? waits : MAXW;
        e = idle(st);
        e.mrd = rd;
        e.mwr = wr;
        for (int i = 0; i < n; i++) push(e, 1'b0, rop());
        if (waits >= MAXW) begin
            plan_trap(4);
            trapped = 1'b1;
        end else begin
            if (st == 3'd0) begin
                e.pcw = 1'b1;
                e.irw = 1'b1;
            end
            push(e, 1'b1, rop());
            trapped = 1'b0;
        end
    endtask

    // Expected trace of one instruction, starting in FETCH.
    task automatic plan_instr(input logic [6:0] op, input int fw, input int mw);
        obs_t e;
        int   k;
        bit   tr;
        k = kind_of(op);
        plan_wait(3'd0, 1'b1, 1'b0, fw, tr);
        if (tr) return;
        push(idle(3'd1), rbit(), op);
        if (k == K_ILL) begin
            plan_trap(10);
            return;
        end
        e = idle(3'd2);
        case (k)
            K_R:   e.aop = 3'd2;
            K_I:   begin e.aop = 3'd3; e.asrc = 1'b1; end
            K_BEQ: begin e.aop = 3'd1; e.br = 1'b1; end
            K_JAL, K_JALR: begin e.asrc = 1'b1; e.jmp = 1'b1; end
            default: e.asrc = 1'b1;
        endcase
        push(e, rbit(), rop());
        if (k == K_BEQ) return;
        if (k == K_LW || k == K_SW) begin
            plan_wait(3'd3, k == K_LW, k == K_SW, mw, tr);
            if (tr || k == K_SW) return;
        end
        e = idle(3'd4);
        e.rw  = 1'b1;
        e.m2r = (k == K_LW);
        push(e, rbit(), rop());
    endtask

    // Entered and left at a falling edge; inputs are applied for the next rising edge.
    task automatic drive_cycle(input bit mr, input logic [6:0] op, output obs_t o);
        mem_ready = mr;
        opcode    = op;
        #1;
        o = sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs_t o;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        opcode    = rop();
        #1;
        o = sample();
        total++;
        if (o[12:0] !== 13'd0) begin
            bad++;
            $display("FAIL reset_pre_edge: got %h expected 0000 (state ignored)", o[12:0]);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mem_ready = rbit();
            #1;
            o = sample();
            total++;
            if (o !== 16'h0000) begin
                bad++;
                $display("FAIL reset_hold cycle %0d: got %h expected 0000", i, o);
            end
            @(negedge clk);
        end
        rst_n     = 1'b1;
        mem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        obs_t o;
        logic [6:0] ops[6];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110011};
        clear_plan();
        foreach (ops[j]) plan_instr(ops[j], 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            drive_cycle(mr_q[i], op_q[i], o);
            total++;
            if (o !== exp_q[i]) begin
                bad++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", i, o, exp_q[i]);
            end
        end
    endtask

    task automatic test_sw_wait();
        obs_t o;
        clear_plan();
        plan_instr(7'b0100011, 0, 3);
        plan_instr(7'b0110011, 1, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            drive_cycle(mr_q[i], op_q[i], o);
            total++;
            if (o !== exp_q[i]) begin
                bad++;
                $display("FAIL sw_wait cycle %0d: got %h expected %h", i, o, exp_q[i]);
            end
        end
    endtask

    task automatic test_illegal();
        obs_t o;
        clear_plan();
        plan_instr(7'b1111111, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            drive_cycle(mr_q[i], op_q[i], o);
            total++;
            if (o !== exp_q[i]) begin
                bad++;
                $display("FAIL illegal_trap cycle %0d: got %h expected %h", i, o, exp_q[i]);
            end
        end
        test_reset();
    endtask

    task automatic test_timeouts();
        obs_t o;
        logic [6:0] ops[4];
        int fws[4];
        int mws[4];
        ops = '{7'b0110011, 7'b0110011, 7'b0000011, 7'b0100011};
        fws = '{MAXW, MAXW - 1, 0, 0};
        mws = '{0, 0, MAXW, MAXW - 1};
        for (int t = 0; t < 4; t++) begin
            clear_plan();
            plan_instr(ops[t], fws[t], mws[t]);
            for (int i = 0; i < exp_q.size(); i++) begin
                drive_cycle(mr_q[i], op_q[i], o);
                total++;
                if (o !== exp_q[i]) begin
                    bad++;
                    $display("FAIL timeout_%0d cycle %0d: got %h expected %h", t, i, o, exp_q[i]);
                end
            end
            if (exp_q[exp_q.size() - 1].trp) test_reset();
        end
    endtask

    task automatic test_reset_mid_mem();
        obs_t o;
        clear_plan();
        plan_instr(7'b0000011, 0, 2 * MAXW);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(mr_q[i], op_q[i], o);
            total++;
            if (o !== exp_q[i]) begin
                bad++;
                $display("FAIL mid_mem_prefix cycle %0d: got %h expected %h", i, o, exp_q[i]);
            end
        end
        test_reset();
        clear_plan();
        plan_instr(7'b0100011, 0, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            drive_cycle(mr_q[i], op_q[i], o);
            total++;
            if (o !== exp_q[i]) begin
                bad++;
                $display("FAIL mid_mem_restart cycle %0d: got %h expected %h", i, o, exp_q[i]);
            end
        end
    endtask

    task automatic test_jump();
        obs_t o;
        logic [6:0] ops[4];
        ops = '{7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        for (int t = 0; t < 4; t++) begin
            clear_plan();
            plan_instr(ops[t], 0, 0);
            for (int i = 0; i < exp_q.size(); i++) begin
                drive_cycle(mr_q[i], op_q[i], o);
                total++;
                if (o !== exp_q[i]) begin
                    bad++;
                    $display("FAIL jump_%0d cycle %0d: got %h expected %h", t, i, o, exp_q[i]);
                end
            end
            if (kind_of(ops[t]) == K_ILL) test_reset();
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [6:0] ops[9];
        int hi;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        hi = JUMP_EN ? 8 : 4;
        clear_plan();
        for (int n = 0; n < 40; n++) begin
            plan_instr(ops[$urandom_range(0, hi)], $urandom_range(0, 4), $urandom_range(0, 4));
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            drive_cycle(mr_q[i], op_q[i], o);
            total++;
            if (o !== exp_q[i]) begin
                bad++;
                $display("FAIL random cycle %0d: got %h expected %h", i, o, exp_q[i]);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        opcode    = 7'd0;
        test_reset();
        test_back_to_back();
        test_sw_wait();
        test_illegal();
        test_timeouts();
        test_reset_mid_mem();
        test_jump();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
